// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with a configurable frame format.
// Each bit is sampled at mid-bit. The receiver flags parity, framing, break
// and overrun conditions, and holds one word until the consumer pulses
// `recieved`.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 recieved,
   output logic [DATA_BITS-1:0] data,
   output logic                 sent,
   output logic [3:0]           error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 par_err_q, par_err_d;
   logic                 brk_cand_q, brk_cand_d;
   logic                 brk_q, brk_d;
   logic                 fr_q, fr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 sent_q, sent_d;
   logic [3:0]           err_q, err_d;
   logic                 sync1_q, rxs_q, rxs_prev_q;
   logic                 tick, fr_now, brk_now;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   // All three reset high, so a line that is idle at release shows no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rx;
         rxs_q      <= sync1_q;
         rxs_prev_q <= rxs_q;
      end
   end

   // State, counters, frame accumulators and the held output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_q       <= '0;
         par_err_q  <= 1'b0;
         brk_cand_q <= 1'b0;
         brk_q      <= 1'b0;
         fr_q       <= 1'b0;
         data_q     <= '0;
         sent_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_q       <= sh_d;
         par_err_q  <= par_err_d;
         brk_cand_q <= brk_cand_d;
         brk_q      <= brk_d;
         fr_q       <= fr_d;
         data_q     <= data_d;
         sent_q     <= sent_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic: mid-bit sampling, error accumulation, completion and handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      sh_d       = sh_q;
      par_err_d  = par_err_q;
      brk_cand_d = brk_cand_q;
      brk_d      = brk_q;
      fr_d       = fr_q;
      data_d     = data_q;
      sent_d     = sent_q;
      err_d      = err_q;
      fr_now     = 1'b0;
      brk_now    = 1'b0;
      tick       = (cnt_q == '0);

      // The acknowledge clears the flag. A completion in this same cycle
      // overrides it below and loads the new word.
      if (sent_q && recieved) begin
         sent_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               cnt_d   = HALF_M1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (rxs_q) begin
               // A low pulse shorter than half a bit is a false start.
               state_d = S_IDLE;
            end else begin
               cnt_d   = FULL_M1;
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
               cnt_d = FULL_M1;
               if (idx_q == LAST_DATA) begin
                  brk_cand_d = (sh_d == '0);
                  par_err_d  = 1'b0;
                  fr_d       = 1'b0;
                  idx_d      = '0;
                  state_d    = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_PAR: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               par_err_d  = ((^sh_q) ^ rxs_q) != (PARITY == 2);
               brk_cand_d = brk_cand_q & ~rxs_q;
               cnt_d      = FULL_M1;
               idx_d      = '0;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               fr_now  = fr_q | ~rxs_q;
               // Only the first stop bit takes part in break detection.
               brk_now = (idx_q == '0) ? (brk_cand_q & ~rxs_q) : brk_q;
               fr_d    = fr_now;
               brk_d   = brk_now;
               cnt_d   = FULL_M1;
               if (idx_q == LAST_STOP) begin
                  if (!sent_q || recieved) begin
                     data_d = sh_q;
                     err_d  = {brk_now, 1'b0, fr_now, par_err_q};
                     sent_d = 1'b1;
                  end else begin
                     err_d[2] = 1'b1;
                  end
                  state_d = (fr_now || brk_now) ? S_WAIT_IDLE : S_IDLE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rxs_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign data  = data_q;
   assign sent  = sent_q;
   assign error = err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame. Two configurations run side by side:
// instance 0 uses 8 data bits, even parity and 1 stop bit; instance 1 uses
// 7 data bits, odd parity and 2 stop bits. A frame-level reference model
// derives the expected data, error, overrun and handshake state from the
// line levels the bench drives.
module tb_uart_rx_frame;

   localparam int C = 16;

   logic       clk, rst_n;
   logic       rx_a, rx_b, ack_a, ack_b;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       sent_a, sent_b;
   logic [3:0] err_a, err_b;

   int cfg_d [2] = '{8, 7};
   int cfg_p [2] = '{1, 2};
   int cfg_s [2] = '{1, 2};

   // Reference model: the held word, the error flags and the sent flag.
   logic [8:0] m_data [2];
   logic [3:0] m_err  [2];
   logic       m_sent [2];

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .recieved(ack_a),
      .data(data_a), .sent(sent_a), .error(err_a));

   uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .recieved(ack_b),
      .data(data_b), .sent(sent_b), .error(err_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input int i, input string tag);
      if (i == 0) begin
         chk({tag, "_a_data"},  {24'd0, data_a}, {23'd0, m_data[0]});
         chk({tag, "_a_err"},   {28'd0, err_a},  {28'd0, m_err[0]});
         chk({tag, "_a_sent"},  {31'd0, sent_a}, {31'd0, m_sent[0]});
      end else begin
         chk({tag, "_b_data"},  {25'd0, data_b}, {23'd0, m_data[1]});
         chk({tag, "_b_err"},   {28'd0, err_b},  {28'd0, m_err[1]});
         chk({tag, "_b_sent"},  {31'd0, sent_b}, {31'd0, m_sent[1]});
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_data[i] = '0;
         m_err[i]  = '0;
         m_sent[i] = 1'b0;
      end
   endtask

   task automatic set_rx(input int i, input logic v);
      if (i == 0) rx_a = v;
      else        rx_b = v;
   endtask

   // Apply one completed frame, given as its line levels, to the model.
   task automatic model_bits(input int i, input logic q[$]);
      int         d, p, s, ps;
      logic [8:0] dv;
      logic       pb, pe, fr, brk;
      d  = cfg_d[i];
      p  = cfg_p[i];
      s  = cfg_s[i];
      ps = (p != 0) ? 1 : 0;
      dv = '0;
      for (int k = 0; k < d; k++) dv[k] = q[1 + k];
      pb = (p != 0) ? q[1 + d] : 1'b0;
      pe = (p != 0) && (((^dv) ^ pb) != (p == 2));
      fr = 1'b0;
      for (int k = 0; k < s; k++) if (q[1 + d + ps + k] == 1'b0) fr = 1'b1;
      brk = (dv == '0) && !pb && (q[1 + d + ps] == 1'b0);
      if (!m_sent[i]) begin
         m_data[i] = dv;
         m_err[i]  = {brk, 1'b0, fr, pe};
         m_sent[i] = 1'b1;
      end else begin
         m_err[i][2] = 1'b1;
      end
   endtask

   task automatic drive_bits(input int i, input logic q[$]);
      foreach (q[k]) begin
         set_rx(i, q[k]);
         repeat (C) @(posedge clk);
         #1;
      end
   endtask

   task automatic build_frame(input int i, input logic [8:0] dv, input bit bad_par,
                              input logic [1:0] stops, output logic q[$]);
      logic [8:0] mask;
      mask = 9'((1 << cfg_d[i]) - 1);
      q = {};
      q.push_back(1'b0);
      for (int k = 0; k < cfg_d[i]; k++) q.push_back(dv[k]);
      if (cfg_p[i] != 0) q.push_back((^(dv & mask)) ^ (cfg_p[i] == 2) ^ bad_par);
      for (int k = 0; k < cfg_s[i]; k++) q.push_back(stops[k]);
   endtask

   // Line is left at the level of the last stop bit.
   task automatic send_frame(input int i, input logic [8:0] dv, input bit bad_par,
                             input logic [1:0] stops);
      logic q[$];
      build_frame(i, dv, bad_par, stops, q);
      drive_bits(i, q);
      model_bits(i, q);
   endtask

   task automatic idle(input int i, input int nbits);
      set_rx(i, 1'b1);
      repeat (nbits * C) @(posedge clk);
      #1;
   endtask

   task automatic ack(input int i);
      if (i == 0) ack_a = 1'b1; else ack_b = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) ack_a = 1'b0; else ack_b = 1'b0;
      m_sent[i] = 1'b0;
      chk("ack_sent", (i == 0) ? {31'd0, sent_a} : {31'd0, sent_b}, 32'd0);
   endtask

   initial begin
      int         lat, exp_lat;
      logic       zq[$];
      logic       fq[$];
      logic [8:0] dv;
      logic [1:0] stops;
      bit         bp;
      int         gap;

      rst_n = 1'b0;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      ack_a = 1'b0;
      ack_b = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_state(0, "reset");
      check_state(1, "reset");

      // 0xA5 with correct parity; sent rises 2 synchroniser cycles plus
      // C/2 + (N-1)*C + 1 after the start bit hits the pin, with N = 11.
      exp_lat = 2 + C / 2 + (11 - 1) * C + 1;
      lat = 0;
      fork
         send_frame(0, 9'h0A5, 1'b0, 2'b11);
         begin
            while (!sent_a && lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      chk("t1_latency", lat, exp_lat);
      check_state(0, "t1");
      idle(0, 1);
      ack(0);
      check_state(0, "t1_ack");

      // 0x3C with a wrong parity bit.
      send_frame(0, 9'h03C, 1'b1, 2'b11);
      check_state(0, "t2");
      idle(0, 1);
      ack(0);

      // 0x55 with stop bit 0, line then held low: no new frame while low.
      send_frame(0, 9'h055, 1'b0, 2'b00);
      check_state(0, "t3");
      ack(0);
      repeat (3 * C) @(posedge clk);
      #1;
      check_state(0, "t3_low");
      idle(0, 1);
      check_state(0, "t3_high");

      // Break: line low for 12 bit times gives exactly one frame.
      zq = {};
      for (int k = 0; k < 11; k++) zq.push_back(1'b0);
      set_rx(0, 1'b0);
      repeat (12 * C) @(posedge clk);
      #1;
      model_bits(0, zq);
      check_state(0, "t4_break");
      idle(0, 2);
      check_state(0, "t4_one");
      ack(0);
      idle(0, 1);
      check_state(0, "t4_none");
      send_frame(0, 9'h081, 1'b0, 2'b11);
      check_state(0, "t4_after");
      idle(0, 1);
      ack(0);

      // Back-to-back frames with no acknowledge: the second overruns.
      send_frame(0, 9'h011, 1'b0, 2'b11);
      send_frame(0, 9'h022, 1'b0, 2'b11);
      check_state(0, "t5_ovr");
      idle(0, 1);
      ack(0);
      send_frame(0, 9'h033, 1'b0, 2'b11);
      check_state(0, "t5_after");
      idle(0, 1);
      ack(0);

      // Short low glitch must not start a frame.
      set_rx(0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      idle(0, 3);
      check_state(0, "t6_glitch");

      // Directed frames on the second configuration.
      send_frame(1, 9'h055, 1'b0, 2'b11);
      check_state(1, "b_ok");
      idle(1, 1);
      ack(1);
      send_frame(1, 9'h02A, 1'b0, 2'b01);
      check_state(1, "b_stop2");
      idle(1, 1);
      ack(1);
      zq = {};
      for (int k = 0; k < 11; k++) zq.push_back(1'b0);
      set_rx(1, 1'b0);
      repeat (12 * C) @(posedge clk);
      #1;
      model_bits(1, zq);
      check_state(1, "b_break");
      idle(1, 1);
      ack(1);

      // Randomised frames on both configurations.
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 25; n++) begin
            dv = 9'($urandom) & 9'((1 << cfg_d[i]) - 1);
            if ($urandom_range(0, 7) == 0) dv = '0;
            bp = ($urandom_range(0, 3) == 0);
            stops = 2'b11;
            if ($urandom_range(0, 4) == 0) stops[$urandom_range(0, cfg_s[i] - 1)] = 1'b0;
            send_frame(i, dv, bp, stops);
            check_state(i, "rnd");
            gap = $urandom_range(0, 2);
            if (stops != 2'b11 && gap == 0) gap = 1;
            if (gap > 0) begin
               idle(i, gap);
               if ($urandom_range(0, 1) == 1) ack(i);
            end
         end
         idle(i, 1);
         ack(i);
      end

      // Leave a word held on B, then reset A mid-frame during its stop bit.
      send_frame(1, 9'h011, 1'b0, 2'b11);
      idle(1, 1);
      build_frame(0, 9'h0F0, 1'b0, 2'b11, fq);
      fork
         drive_bits(0, fq);
         begin
            repeat (163) @(posedge clk);
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      model_reset();
      idle(0, 1);
      check_state(0, "rst_mid");
      check_state(1, "rst_mid");
      send_frame(0, 9'h00F, 1'b0, 2'b11);
      check_state(0, "rst_after");
      send_frame(1, 9'h00F, 1'b0, 2'b11);
      check_state(1, "rst_after");
      idle(0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that supersedes the fixed 8-bit, one-sample-per-bit receiver.
- Oversamples `rx` and samples each bit at mid-bit.
- Configurable: data width, parity mode and stop-bit count.
- Checks parity, framing, break and overrun.
- Holds one received word for the consumer under the existing `sent`/`recieved` handshake.
- Sits between the board RX pin and the command/data consumer logic.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; legal ≥ 4; even values give exact mid-bit sampling.
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `recieved` input 1: consumer acknowledge for the held word.
- `data` output DATA_BITS: held word, LSB = first data bit received.
- `sent` output 1: high while `data`/`error` hold an unacknowledged frame.
- `error` output 4: bit0 parity, bit1 framing, bit2 overrun, bit3 break.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser, both flops reset to 1. All logic uses the synchronised value `rxs`.
- **States:** IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- **IDLE:** a 1→0 transition on `rxs` loads the bit counter with CLKS_PER_BIT/2−1 and enters START.
- **START:** at counter expiry, sample `rxs`.
  - If 1: false start; return to IDLE; no output change.
  - If 0: reload the counter with CLKS_PER_BIT−1 and enter DATA.
- **DATA:** at each expiry, shift `rxs` into the shift register, LSB first. After DATA_BITS samples, go to PAR if PARITY≠0, else STOP.
- **PAR:** sample one bit.
  - Parity error when the XOR of data bits and parity bit ≠ 0 (even mode) or ≠ 1 (odd mode).
- **STOP:** sample STOP_BITS bits. Framing error if any stop sample is 0.
- **Break:** data all zero, parity bit (if present) 0, and the first stop bit 0.
- **Frame completion** (cycle after the last stop sample):
  - If `sent`=0, or `recieved`=1 in the same cycle: load `data` and `error[3,1,0]`, clear `error[2]`, set `sent`=1.
  - If `sent`=1 and `recieved`=0: drop the frame; `data` and `error[3,1,0]` unchanged; set `error[2]`.
- **After completion:**
  - On framing error or break, enter WAIT_IDLE and remain there until `rxs`=1, then go to IDLE. No new start is detected while in WAIT_IDLE.
  - Otherwise go directly to IDLE.
- **Handshake:** `sent` stays high until `recieved` is sampled high; it clears on the next edge. `error` and `data` hold their values after the clear. `recieved` while `sent`=0 is ignored.
- **Delivery:** frames with parity, framing or break errors are still delivered; the consumer decides from `error`.
- **Reset:** asynchronous, valid at any point including mid-frame.
  - `data`=0, `sent`=0, `error`=0, state IDLE, counters 0, synchroniser = 1.
  - A partial frame is discarded. After release, the receiver re-arms on the next falling edge of `rxs`.

## Timing
- Let T0 be the cycle in which IDLE sees `rxs` fall; T0 is 2–3 cycles after the pin falls.
- Sample k (k=0 is the start bit) is taken at T0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS samples per frame.
- `sent` rises at T0 + CLKS_PER_BIT/2 + (N−1)·CLKS_PER_BIT + 1.
- Back-to-back frames (no idle gap) are received without loss: IDLE is re-entered at least CLKS_PER_BIT/2−1 cycles before the next start edge.
- Counter width: ceil(log2(CLKS_PER_BIT)). No arithmetic wrap is allowed; counters reload on expiry.
- Glitch rejection: a low pulse shorter than CLKS_PER_BIT/2 cycles on `rxs` is a false start.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, PARITY=1 (even), STOP_BITS=1 unless stated.
1. Send 0xA5 with parity 0, stop 1 → `data`=0xA5, `error`=4'b0000, `sent` rises at T0+8+10·16+1. Assert `recieved` for 1 cycle → `sent`=0 next edge.
2. Send 0x3C with parity bit 1 → `data`=0x3C, `error`=4'b0001, `sent`=1.
3. Send 0x55 with stop bit 0, then hold the line low for 3 more bit times → `error`=4'b0010. No new frame starts until `rx` returns high.
4. Hold `rx` low for 12 bit times → `data`=0x00, `error`=4'b1010, exactly one frame delivered. Then send 0x81 → `data`=0x81, `error`=0.
5. Send 0x11 then 0x22 back-to-back with no ack → `data`=0x11, `error[2]`=1. After ack, send 0x33 → `data`=0x33, `error`=0.
6. Drive a 5-cycle low glitch → `sent` stays 0. Assert `rst_n` low mid-frame during 0xF0, then send 0x0F → `data`=0x0F, `error`=0; run again with PARITY=2, STOP_BITS=2, DATA_BITS=7.
